// File: rtl/nuc_pkg.sv
// Shared nucleotide definitions for the sampler / estimator pair.
// Codes, the per-mille scale and the estimator FSM states live here.
package nuc_pkg;

   localparam logic [1:0] NUC_A = 2'b00;
   localparam logic [1:0] NUC_C = 2'b01;
   localparam logic [1:0] NUC_G = 2'b10;
   localparam logic [1:0] NUC_T = 2'b11;

   localparam int PERMILLE = 1000;
   localparam int PROB_W   = 10;

   typedef enum logic [1:0] {
      S_COLLECT = 2'd0,
      S_DIVIDE  = 2'd1,
      S_HOLD    = 2'd2
   } est_state_t;

endpackage

// File: rtl/nuc_freq_estimator_if.sv
// Sample-in / result-out handshake bundle for nuc_freq_estimator.
// The slave modport is the estimator and the master modport is its environment.
interface nuc_freq_estimator_if;
   import nuc_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [1:0]        in_nuc;
   logic              out_valid;
   logic              out_ready;
   logic [PROB_W-1:0] prob_A;
   logic [PROB_W-1:0] prob_C;
   logic [PROB_W-1:0] prob_G;
   logic [PROB_W-1:0] prob_T;
   logic              busy;

   modport slave (
      input  in_valid, in_nuc, out_ready,
      output in_ready, out_valid, prob_A, prob_C, prob_G, prob_T, busy
   );

   modport master (
      output in_valid, in_nuc, out_ready,
      input  in_ready, out_valid, prob_A, prob_C, prob_G, prob_T, busy
   );

endinterface

// File: rtl/nuc_div_serial.sv
// Restoring divider that produces a fixed-width quotient, one bit per clock edge.
// The start edge already resolves the MSB, so a full quotient takes QUOT_W edges.
module nuc_div_serial
   import nuc_pkg::*;
#(
   parameter int DEN_W = 10,
   parameter int NUM_W = DEN_W + PROB_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [NUM_W-1:0]  num,
   input  logic [DEN_W-1:0]  den,
   output logic              busy,
   output logic              done,
   output logic [PROB_W-1:0] quot
);

   localparam int QUOT_W = PROB_W;

   logic [DEN_W-1:0]  rem;
   logic [QUOT_W-1:0] low;
   logic [3:0]        steps;

   logic [DEN_W-1:0]  rem_in;
   logic              bit_in;
   logic [DEN_W:0]    trial;
   logic              fits;
   logic [DEN_W-1:0]  rem_next;

   // The caller guarantees num < den * 2**QUOT_W, so the top DEN_W bits are already below den.
   always_comb begin
      rem_in   = busy ? rem : num[NUM_W-1:QUOT_W];
      bit_in   = busy ? low[QUOT_W-1] : num[QUOT_W-1];
      trial    = {rem_in, bit_in};
      fits     = (trial >= {1'b0, den});
      rem_next = fits ? DEN_W'(trial - {1'b0, den}) : trial[DEN_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rem   <= '0;
         low   <= '0;
         steps <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         quot  <= '0;
      end else begin
         done <= 1'b0;
         if (busy) begin
            rem   <= rem_next;
            low   <= {low[QUOT_W-2:0], 1'b0};
            quot  <= {quot[QUOT_W-2:0], fits};
            steps <= steps + 4'd1;
            if (steps == 4'(QUOT_W - 1)) begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end else if (start) begin
            rem   <= rem_next;
            low   <= {num[QUOT_W-2:0], 1'b0};
            quot  <= {{(QUOT_W-1){1'b0}}, fits};
            steps <= 4'd1;
            busy  <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/nuc_freq_estimator.sv
// Counts nucleotides over a window of WINDOW samples and reports per-mille probabilities.
// A, C and G are truncated quotients; T takes the residue so the four always sum to 1000.
module nuc_freq_estimator
   import nuc_pkg::*;
#(
   parameter int WINDOW = 1000
) (
   input  logic                  clk,
   input  logic                  reset,
   nuc_freq_estimator_if.slave   bus
);

   localparam int CNT_W = $clog2(WINDOW + 1);
   localparam int NUM_W = CNT_W + PROB_W;

   est_state_t        state;
   logic [CNT_W-1:0]  cnt_a, cnt_c, cnt_g, cnt_t, sample_cnt;
   logic [1:0]        sel;
   logic [PROB_W-1:0] q_a, q_c;
   logic [PROB_W-1:0] prob_a, prob_c, prob_g, prob_t;
   logic              out_valid;

   logic              div_start, div_busy, div_done;
   logic [PROB_W-1:0] div_quot;
   logic [1:0]        div_idx;
   logic [CNT_W-1:0]  div_cnt;
   logic [NUM_W-1:0]  div_num;
   logic [PROB_W:0]   sum3, prob_t_next;
   logic              in_ready, accept;

   assign in_ready = (state == S_COLLECT);
   assign accept   = bus.in_valid && in_ready;

   // A division finishing and the next one starting share an edge, so the operand looks one ahead.
   always_comb begin
      div_idx = div_done ? sel + 2'd1 : sel;
      case (div_idx)
         2'd0:    div_cnt = cnt_a;
         2'd1:    div_cnt = cnt_c;
         2'd2:    div_cnt = cnt_g;
         default: div_cnt = cnt_t;
      endcase
      div_num     = NUM_W'(div_cnt) * NUM_W'(PERMILLE);
      div_start   = (state == S_DIVIDE) && !div_busy && !(div_done && sel == 2'd2);
      sum3        = (PROB_W+1)'(q_a) + (PROB_W+1)'(q_c) + (PROB_W+1)'(div_quot);
      prob_t_next = (PROB_W+1)'(PERMILLE) - sum3;
   end

   nuc_div_serial #(.DEN_W(CNT_W), .NUM_W(NUM_W)) u_div (
      .clk   (clk),
      .reset (reset),
      .start (div_start),
      .num   (div_num),
      .den   (CNT_W'(WINDOW)),
      .busy  (div_busy),
      .done  (div_done),
      .quot  (div_quot)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_COLLECT;
         cnt_a      <= '0;
         cnt_c      <= '0;
         cnt_g      <= '0;
         cnt_t      <= '0;
         sample_cnt <= '0;
         sel        <= 2'd0;
         q_a        <= '0;
         q_c        <= '0;
         prob_a     <= '0;
         prob_c     <= '0;
         prob_g     <= '0;
         prob_t     <= '0;
         out_valid  <= 1'b0;
      end else begin
         case (state)
            S_COLLECT: begin
               if (accept) begin
                  case (bus.in_nuc)
                     NUC_A:   cnt_a <= cnt_a + 1'b1;
                     NUC_C:   cnt_c <= cnt_c + 1'b1;
                     NUC_G:   cnt_g <= cnt_g + 1'b1;
                     default: cnt_t <= cnt_t + 1'b1;
                  endcase
                  if (sample_cnt == CNT_W'(WINDOW - 1)) begin
                     sample_cnt <= '0;
                     sel        <= 2'd0;
                     state      <= S_DIVIDE;
                  end else begin
                     sample_cnt <= sample_cnt + 1'b1;
                  end
               end
            end
            S_DIVIDE: begin
               if (div_done) begin
                  case (sel)
                     2'd0: begin
                        q_a <= div_quot;
                        sel <= 2'd1;
                     end
                     2'd1: begin
                        q_c <= div_quot;
                        sel <= 2'd2;
                     end
                     default: begin
                        prob_a    <= q_a;
                        prob_c    <= q_c;
                        prob_g    <= div_quot;
                        prob_t    <= prob_t_next[PROB_W-1:0];
                        out_valid <= 1'b1;
                        state     <= S_HOLD;
                     end
                  endcase
               end
            end
            S_HOLD: begin
               if (bus.out_ready) begin
                  out_valid <= 1'b0;
                  cnt_a     <= '0;
                  cnt_c     <= '0;
                  cnt_g     <= '0;
                  cnt_t     <= '0;
                  state     <= S_COLLECT;
               end
            end
            default: state <= S_COLLECT;
         endcase
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.prob_A    = prob_a;
   assign bus.prob_C    = prob_c;
   assign bus.prob_G    = prob_g;
   assign bus.prob_T    = prob_t;
   assign bus.busy      = (state != S_COLLECT);

endmodule

// File: doc/nuc_freq_estimator.md
Name: nuc_freq_estimator

Overview:
Inverse of the team's weighted nucleotide sampler. It consumes a stream of 2-bit nucleotide codes, counts occurrences over a fixed window of WINDOW samples, and converts the counts to per-mille probabilities. The four probabilities always sum to exactly 1000 and can feed the sampler's prob_A..prob_T inputs directly. It sits after a sequence source or sampler output and closes the loop for statistical self-check of generated sequences.

Parameters:
WINDOW, 1000, samples per estimation window; legal range 1..65535.
CNT_W, derived localparam = clog2(WINDOW+1), per-symbol counter width; not overridable.

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  in_nuc is valid this cycle
in_ready  output  1  block accepts a sample this cycle
in_nuc  input  2  nucleotide code: A=00, C=01, G=10, T=11
out_valid  output  1  prob_* hold a completed window result
out_ready  input  1  consumer accepts the result
prob_A  output  10  per-mille probability of A
prob_C  output  10  per-mille probability of C
prob_G  output  10  per-mille probability of G
prob_T  output  10  per-mille probability of T
busy  output  1  high in DIVIDE and HOLD states

Behaviour:
- Reset (synchronous, active-high, clk rising edge): state=COLLECT, all counters and the sample counter=0, out_valid=0, prob_A..prob_T=0, busy=0. in_ready=1 from the first cycle after reset deasserts. Reset mid-DIVIDE or mid-HOLD discards all partial work.
- Handshakes: a sample is accepted on an edge where in_valid&&in_ready. A result is consumed on an edge where out_valid&&out_ready. in_ready is combinational from state only: 1 in COLLECT, 0 otherwise. in_ready does not depend on in_valid.
- FSM COLLECT: each accepted sample increments the matching count (cnt_A/C/G/T) and the sample counter. On the edge accepting sample number WINDOW, go to DIVIDE. Samples offered while not in COLLECT are not accepted (backpressure).
- FSM DIVIDE: serial restoring division computes q = floor(cnt*1000 / WINDOW) for A, then C, then G.
  - 10 cycles per division; the 10-bit quotient is sufficient because cnt ≤ WINDOW, so q ≤ 1000.
  - Numerator width is CNT_W+10 bits, computed without overflow.
  - Division occupies 30 edges. The following edge (FINAL) sets prob_T = 1000 − (prob_A+prob_C+prob_G), 11-bit intermediate, always ≥ 0.
  - FINAL also loads all prob_* registers and sets out_valid=1.
  - out_valid rises exactly 31 edges after the edge that accepted the final sample.
- FSM HOLD: out_valid=1; prob_* stay stable while out_ready=0, for any number of cycles. On the consuming edge:
  - out_valid←0;
  - counters cleared;
  - state←COLLECT, so in_ready=1 in the next cycle.
  - prob_* keep their last value after consumption, until the next FINAL.
- Rounding: A, C and G truncate. T absorbs all rounding residue, so the sum of the four outputs is always exactly 1000.
- A count of 0 gives probability 0. WINDOW=1 is legal: the single symbol gets 1000 and the rest get 0. If that symbol is T, T receives 1000 through the residue rule.
- Simultaneous events: none are possible between the input and output handshakes, because in_ready and out_valid are never both high.

Decomposition:
- Shared package nuc_pkg:
  - nucleotide code constants NUC_A=2'b00, NUC_C=2'b01, NUC_G=2'b10, NUC_T=2'b11 (shared with the sampler);
  - PERMILLE=1000;
  - PROB_W=10;
  - FSM state enumeration.
- Sub-module nuc_div_serial: restoring divider with start/done, fixed 10 quotient bits, parameterised numerator and denominator widths. The estimator instantiates one copy and reuses it three times.

Test Plan:
1. WINDOW=8, 8×A back-to-back with in_valid=1 -> out_valid rises 31 cycles after the 8th accept; A=1000, C=0, G=0, T=0.
2. WINDOW=8, stream AACCGGTT -> 250/250/250/250.
3. WINDOW=8, stream AAACCCGT -> A=375, C=375, G=125, T=125.
4. WINDOW=3, stream ACG -> A=333, C=333, G=333, T=1 (sum 1000); a second window TTT -> A=0, C=0, G=0, T=1000.
5. Backpressure: hold out_ready=0 for 20 cycles with in_valid=1 -> in_ready stays 0, prob_* stable, no sample counted. Raise out_ready -> in_ready=1 next cycle and the new window counts from 0.
6. Reset asserted for 1 cycle mid-DIVIDE -> next cycle out_valid=0, in_ready=1, counters 0. A following full window gives correct results unaffected by the aborted one.
